// File: rtl/register_file_mp_if.sv
// Bus bundle for register_file_mp: read, write and reservation ports plus
// the registered read results and scoreboard bits.
interface register_file_mp_if #(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned DEPTH      = 16,
    parameter int unsigned ADDR_WIDTH = $clog2(DEPTH),
    parameter int unsigned NUM_READ   = 2,
    parameter int unsigned NUM_WRITE  = 2
);
    logic [NUM_READ-1:0]             read_en;
    logic [NUM_READ*ADDR_WIDTH-1:0]  raddr;
    logic [NUM_READ*DATA_WIDTH-1:0]  rdata;
    logic [NUM_READ-1:0]             rvalid;
    logic [NUM_WRITE-1:0]            write_en;
    logic [NUM_WRITE*ADDR_WIDTH-1:0] waddr;
    logic [NUM_WRITE*DATA_WIDTH-1:0] wdata;
    logic                            reserve_en;
    logic [ADDR_WIDTH-1:0]           reserve_addr;
    logic [DEPTH-1:0]                busy;

    // Issue/writeback side
    modport master (
        output read_en, raddr, write_en, waddr, wdata, reserve_en, reserve_addr,
        input  rdata, rvalid, busy
    );

    // Register file side
    modport slave (
        input  read_en, raddr, write_en, waddr, wdata, reserve_en, reserve_addr,
        output rdata, rvalid, busy
    );
endinterface

// File: rtl/register_file_mp.sv
// Multi-port register file with registered reads, same-cycle write/reserve
// bypass, highest-index write-port priority, optional zero register and a
// per-entry busy scoreboard.
module register_file_mp #(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned DEPTH      = 16,
    parameter int unsigned ADDR_WIDTH = $clog2(DEPTH),
    parameter int unsigned NUM_READ   = 2,
    parameter int unsigned NUM_WRITE  = 2,
    parameter int unsigned ZERO_REG   = 0
) (
    input  logic               clk,
    input  logic               reset,
    register_file_mp_if.slave  bus
);

    logic [DATA_WIDTH-1:0]          r_mem [DEPTH];
    logic [DEPTH-1:0]               r_busy;
    logic [NUM_READ*DATA_WIDTH-1:0] r_rdata;
    logic [NUM_READ-1:0]            r_rvalid;

    logic [DATA_WIDTH-1:0]          w_mem_next [DEPTH];
    logic [DEPTH-1:0]               w_busy_next;
    logic [NUM_READ*DATA_WIDTH-1:0] w_rd_data;
    logic [NUM_READ-1:0]            w_rd_busy;

    // Next storage/scoreboard state: writes in ascending port order so the
    // highest index wins; reservation applied last so it overrides a write.
    always_comb begin
        for (int k = 0; k < int'(DEPTH); k++) begin
            w_mem_next[k] = r_mem[k];
        end
        w_busy_next = r_busy;
        for (int j = 0; j < int'(NUM_WRITE); j++) begin
            if (bus.write_en[j] &&
                !(ZERO_REG != 0 && bus.waddr[j*ADDR_WIDTH +: ADDR_WIDTH] == '0)) begin
                w_mem_next[bus.waddr[j*ADDR_WIDTH +: ADDR_WIDTH]] =
                    bus.wdata[j*DATA_WIDTH +: DATA_WIDTH];
                w_busy_next[bus.waddr[j*ADDR_WIDTH +: ADDR_WIDTH]] = 1'b0;
            end
        end
        if (bus.reserve_en && !(ZERO_REG != 0 && bus.reserve_addr == '0)) begin
            w_busy_next[bus.reserve_addr] = 1'b1;
        end
    end

    // Read ports look at next state, which gives the zero-cycle bypass.
    // Entry 0 under ZERO_REG is never written or reserved, so it reads 0/idle.
    always_comb begin
        w_rd_data = '0;
        w_rd_busy = '0;
        for (int i = 0; i < int'(NUM_READ); i++) begin
            w_rd_data[i*DATA_WIDTH +: DATA_WIDTH] =
                w_mem_next[bus.raddr[i*ADDR_WIDTH +: ADDR_WIDTH]];
            w_rd_busy[i] = w_busy_next[bus.raddr[i*ADDR_WIDTH +: ADDR_WIDTH]];
        end
    end

    // Storage and scoreboard registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < int'(DEPTH); k++) begin
                r_mem[k] <= '0;
            end
            r_busy <= '0;
        end else begin
            for (int k = 0; k < int'(DEPTH); k++) begin
                r_mem[k] <= w_mem_next[k];
            end
            r_busy <= w_busy_next;
        end
    end

    // Registered read results; a port without read_en holds its last result
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rdata  <= '0;
            r_rvalid <= '0;
        end else begin
            for (int i = 0; i < int'(NUM_READ); i++) begin
                if (bus.read_en[i]) begin
                    r_rdata[i*DATA_WIDTH +: DATA_WIDTH] <= w_rd_data[i*DATA_WIDTH +: DATA_WIDTH];
                    r_rvalid[i] <= !w_rd_busy[i];
                end
            end
        end
    end

    assign bus.rdata  = r_rdata;
    assign bus.rvalid = r_rvalid;
    assign bus.busy   = r_busy;

endmodule

// File: tb/tb_register_file_mp.sv
// Scoreboard bench for register_file_mp: stimulus queues expected read and
// busy values per cycle, a negedge monitor pops and compares them.
module tb_register_file_mp;

    localparam int unsigned DW = 64;
    localparam int unsigned DP = 16;
    localparam int unsigned AW = 4;
    localparam int unsigned NR = 2;
    localparam int unsigned NW = 2;

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    register_file_mp_if #(.DATA_WIDTH(DW), .DEPTH(DP), .ADDR_WIDTH(AW),
                          .NUM_READ(NR), .NUM_WRITE(NW)) m_if ();
    register_file_mp_if #(.DATA_WIDTH(DW), .DEPTH(DP), .ADDR_WIDTH(AW),
                          .NUM_READ(NR), .NUM_WRITE(NW)) z_if ();

    register_file_mp #(.DATA_WIDTH(DW), .DEPTH(DP), .ADDR_WIDTH(AW),
                       .NUM_READ(NR), .NUM_WRITE(NW), .ZERO_REG(0)) u_dut_m (
        .clk   (clk),
        .reset (reset),
        .bus   (m_if)
    );

    register_file_mp #(.DATA_WIDTH(DW), .DEPTH(DP), .ADDR_WIDTH(AW),
                       .NUM_READ(NR), .NUM_WRITE(NW), .ZERO_REG(1)) u_dut_z (
        .clk   (clk),
        .reset (reset),
        .bus   (z_if)
    );

    typedef struct {
        bit          dut;    // 0 = main, 1 = zero-register build
        bit          kind;   // 0 = read port result, 1 = busy vector
        int          port;
        logic [63:0] data;
        bit          valid;
        logic [15:0] busy;
        int          due;
        int          id;
    } exp_t;

    exp_t        exp_q[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    int          next_id = 0;
    logic [63:0] model [DP];
    logic [63:0] last_d [NR];
    bit          last_v [NR];

    // Monitor: compare every expectation due at this cycle
    exp_t        mon_e;
    logic [63:0] act_d;
    bit          act_v;
    logic [15:0] act_b;
    always @(negedge clk) begin
        while (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
            mon_e = exp_q.pop_front();
            n_tests++;
            if (mon_e.kind == 1'b0) begin
                act_d = mon_e.dut ? z_if.rdata[mon_e.port*64 +: 64] : m_if.rdata[mon_e.port*64 +: 64];
                act_v = mon_e.dut ? z_if.rvalid[mon_e.port] : m_if.rvalid[mon_e.port];
                if (mon_e.due != cyc || act_d !== mon_e.data || act_v !== mon_e.valid) begin
                    n_fail++;
                    $display("FAIL read id=%0d dut=%0d port=%0d cyc=%0d: got data=%h valid=%0b, want data=%h valid=%0b",
                             mon_e.id, mon_e.dut, mon_e.port, cyc, act_d, act_v, mon_e.data, mon_e.valid);
                end
            end else begin
                act_b = mon_e.dut ? z_if.busy : m_if.busy;
                if (mon_e.due != cyc || act_b !== mon_e.busy) begin
                    n_fail++;
                    $display("FAIL busy id=%0d dut=%0d cyc=%0d: got %h, want %h",
                             mon_e.id, mon_e.dut, cyc, act_b, mon_e.busy);
                end
            end
        end
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic idle();
        m_if.read_en = '0; m_if.raddr = '0; m_if.write_en = '0; m_if.waddr = '0;
        m_if.wdata = '0; m_if.reserve_en = 1'b0; m_if.reserve_addr = '0;
        z_if.read_en = '0; z_if.raddr = '0; z_if.write_en = '0; z_if.waddr = '0;
        z_if.wdata = '0; z_if.reserve_en = 1'b0; z_if.reserve_addr = '0;
    endtask

    task automatic rd(input bit d, input int p, input logic [3:0] a);
        if (d) begin z_if.read_en[p] = 1'b1; z_if.raddr[p*4 +: 4] = a; end
        else   begin m_if.read_en[p] = 1'b1; m_if.raddr[p*4 +: 4] = a; end
    endtask

    task automatic wr(input bit d, input int p, input logic [3:0] a, input logic [63:0] v);
        if (d) begin
            z_if.write_en[p] = 1'b1; z_if.waddr[p*4 +: 4] = a; z_if.wdata[p*64 +: 64] = v;
        end else begin
            m_if.write_en[p] = 1'b1; m_if.waddr[p*4 +: 4] = a; m_if.wdata[p*64 +: 64] = v;
        end
    endtask

    task automatic rsv(input bit d, input logic [3:0] a);
        if (d) begin z_if.reserve_en = 1'b1; z_if.reserve_addr = a; end
        else   begin m_if.reserve_en = 1'b1; m_if.reserve_addr = a; end
    endtask

    // Expect a read result after the coming edge
    task automatic exp_rd(input bit d, input int p, input logic [63:0] v, input bit ok);
        exp_t e;
        e.dut = d; e.kind = 1'b0; e.port = p; e.data = v; e.valid = ok;
        e.busy = '0; e.due = cyc + 1; e.id = next_id++;
        exp_q.push_back(e);
        if (!d) begin last_d[p] = v; last_v[p] = ok; end
    endtask

    // Expect an idle main-DUT port to keep its last result
    task automatic exp_hold(input int p);
        exp_rd(1'b0, p, last_d[p], last_v[p]);
    endtask

    task automatic exp_busy(input bit d, input logic [15:0] b);
        exp_t e;
        e.dut = d; e.kind = 1'b1; e.port = 0; e.data = '0; e.valid = 1'b0;
        e.busy = b; e.due = cyc + 1; e.id = next_id++;
        exp_q.push_back(e);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] v;
        reset = 1'b1;
        idle();
        for (int k = 0; k < int'(DP); k++) model[k] = '0;
        last_d[0] = '0; last_d[1] = '0; last_v[0] = 1'b0; last_v[1] = 1'b0;
        step(); step();

        // Reset state
        exp_rd(1'b0, 0, 64'h0, 1'b0); exp_rd(1'b0, 1, 64'h0, 1'b0);
        exp_busy(1'b0, 16'h0); exp_busy(1'b1, 16'h0);
        exp_rd(1'b1, 0, 64'h0, 1'b0);
        step();
        reset = 1'b0;

        // Write entry 3, read it back
        idle(); wr(1'b0, 0, 4'd3, 64'hDEAD_BEEF); model[3] = 64'hDEAD_BEEF; step();
        idle(); rd(1'b0, 0, 4'd3); exp_rd(1'b0, 0, 64'hDEAD_BEEF, 1'b1); step();

        // Mid-run reset with a write and reservation in flight
        idle(); wr(1'b0, 1, 4'd4, 64'hABCD); rsv(1'b0, 4'd4); rd(1'b0, 0, 4'd3);
        #1 reset = 1'b1;
        for (int k = 0; k < int'(DP); k++) model[k] = '0;
        exp_rd(1'b0, 0, 64'h0, 1'b0); exp_rd(1'b0, 1, 64'h0, 1'b0); exp_busy(1'b0, 16'h0);
        step();
        reset = 1'b0;
        idle(); rd(1'b0, 0, 4'd3); rd(1'b0, 1, 4'd4);
        exp_rd(1'b0, 0, 64'h0, 1'b1); exp_rd(1'b0, 1, 64'h0, 1'b1); exp_busy(1'b0, 16'h0);
        step();

        // Walk all entries through write port 0
        for (int k = 0; k < int'(DP); k++) begin
            v = {$urandom(), $urandom()};
            idle(); wr(1'b0, 0, 4'(k), v); model[k] = v; step();
        end
        for (int k = 0; k < int'(DP); k++) begin
            idle(); rd(1'b0, 0, 4'(k)); exp_rd(1'b0, 0, model[k], 1'b1); exp_hold(1); step();
        end
        for (int k = 0; k < int'(DP); k++) begin
            idle(); rd(1'b0, 1, 4'(k)); exp_rd(1'b0, 1, model[k], 1'b1); exp_hold(0); step();
        end
        for (int k = 0; k < int'(DP); k++) begin
            idle(); rd(1'b0, 0, 4'(k)); rd(1'b0, 1, 4'(15 - k));
            exp_rd(1'b0, 0, model[k], 1'b1); exp_rd(1'b0, 1, model[15 - k], 1'b1); step();
        end

        // Same-edge write-to-read bypass
        idle(); wr(1'b0, 0, 4'd5, 64'h1234); model[5] = 64'h1234;
        rd(1'b0, 0, 4'd5); rd(1'b0, 1, 4'd5);
        exp_rd(1'b0, 0, 64'h1234, 1'b1); exp_rd(1'b0, 1, 64'h1234, 1'b1); step();

        // Write-port conflict: port 1 wins
        idle(); wr(1'b0, 0, 4'd7, 64'hAAAA); wr(1'b0, 1, 4'd7, 64'h5555); model[7] = 64'h5555;
        rd(1'b0, 0, 4'd7); exp_rd(1'b0, 0, 64'h5555, 1'b1); exp_hold(1); step();
        idle(); rd(1'b0, 1, 4'd7); exp_rd(1'b0, 1, 64'h5555, 1'b1); exp_hold(0); step();

        // Scoreboard: reserve, busy read, clearing write, reserve+write
        idle(); rsv(1'b0, 4'd9); rd(1'b0, 1, 4'd9);
        exp_rd(1'b0, 1, model[9], 1'b0); exp_hold(0); exp_busy(1'b0, 16'(1) << 9); step();
        idle(); rd(1'b0, 0, 4'd9); exp_rd(1'b0, 0, model[9], 1'b0); exp_busy(1'b0, 16'(1) << 9); step();
        idle(); wr(1'b0, 1, 4'd9, 64'h77); model[9] = 64'h77; rd(1'b0, 0, 4'd9);
        exp_rd(1'b0, 0, 64'h77, 1'b1); exp_busy(1'b0, 16'h0); step();
        idle(); rsv(1'b0, 4'd9); wr(1'b0, 0, 4'd9, 64'h77); rd(1'b0, 0, 4'd9);
        exp_rd(1'b0, 0, 64'h77, 1'b0); exp_busy(1'b0, 16'(1) << 9); step();
        idle(); rd(1'b0, 1, 4'd9); exp_rd(1'b0, 1, 64'h77, 1'b0); exp_busy(1'b0, 16'(1) << 9); step();
        idle(); rsv(1'b0, 4'd2); wr(1'b0, 0, 4'd9, 64'h99); model[9] = 64'h99; rd(1'b0, 0, 4'd9);
        exp_rd(1'b0, 0, 64'h99, 1'b1); exp_busy(1'b0, 16'(1) << 2); step();

        // Zero register build: entry 0 ignores writes and reservations
        idle(); wr(1'b1, 0, 4'd0, 64'hFFFF); rsv(1'b1, 4'd0); rd(1'b1, 0, 4'd0); rd(1'b1, 1, 4'd0);
        exp_rd(1'b1, 0, 64'h0, 1'b1); exp_rd(1'b1, 1, 64'h0, 1'b1); exp_busy(1'b1, 16'h0); step();
        idle(); wr(1'b1, 1, 4'd1, 64'hFFFF); rd(1'b1, 0, 4'd0); rd(1'b1, 1, 4'd1);
        exp_rd(1'b1, 0, 64'h0, 1'b1); exp_rd(1'b1, 1, 64'hFFFF, 1'b1); exp_busy(1'b1, 16'h0); step();

        idle(); step(); step();
        if (exp_q.size() != 0) begin
            $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
            n_fail += exp_q.size();
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/register_file_mp.md
# register_file_mp

Parametrised multi-port register file: the next generation of the 16x64 two-read/one-write register file. Adds configurable width, depth and port counts, registered reads with write-to-read bypass, deterministic write-port priority, an optional hard-wired zero register, and a per-entry busy scoreboard for the issue stage. Sits between decode/issue (reads, reservations) and writeback (writes) in the core pipeline.

## Interface
Parameters:
- DATA_WIDTH, 64, bits per entry
- DEPTH, 16, number of entries (power of two, >= 2)
- ADDR_WIDTH, $clog2(DEPTH), address width
- NUM_READ, 2, read ports (>= 1)
- NUM_WRITE, 2, write ports (>= 1)
- ZERO_REG, 0, 1 = entry 0 always reads zero and ignores writes and reservations

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- read_en  in  NUM_READ  per-port read request
- raddr  in  NUM_READ*ADDR_WIDTH  read addresses; port i at [i*ADDR_WIDTH +: ADDR_WIDTH]
- rdata  out  NUM_READ*DATA_WIDTH  registered read data; port i at [i*DATA_WIDTH +: DATA_WIDTH]
- rvalid  out  NUM_READ  registered: entry read was not busy
- write_en  in  NUM_WRITE  per-port write request
- waddr  in  NUM_WRITE*ADDR_WIDTH  write addresses, packed as raddr
- wdata  in  NUM_WRITE*DATA_WIDTH  write data, packed as rdata
- reserve_en  in  1  mark entry busy (pending writeback)
- reserve_addr  in  ADDR_WIDTH  entry to reserve
- busy  out  DEPTH  current scoreboard bits, bit k = entry k

## Operation
- Storage: DEPTH x DATA_WIDTH flops; busy: DEPTH flops.
- Write: on edge, for each j with write_en[j], entry waddr[j] <= wdata[j]. Same address on several ports: highest-index port wins. Write also clears busy for that entry.
- Reserve: on edge, reserve_en sets busy[reserve_addr]. Same-edge write and reserve to same entry: data written, busy ends set (reservation is newer).
- Read: on edge, if read_en[i]: rdata[i] <= effective value of raddr[i]; rvalid[i] <= !effective busy. If read_en[i] low: rdata[i] and rvalid[i] hold.
- Bypass: effective value = wdata of the winning write port if any write_en targets raddr[i] this cycle, else stored entry. Effective busy = busy[raddr[i]] cleared by same-cycle write, set by same-cycle reserve (reserve wins). No two-cycle hazard window exists.
- ZERO_REG=1: entry 0 reads 0 with rvalid 1; writes and reserves to 0 dropped; busy[0] stays 0.
- Addresses >= DEPTH impossible (DEPTH power of two).

## Timing
- Reset (async assert, sync-safe deassert at edge): all entries 0, busy = 0, rdata = 0, rvalid = 0. Reset mid-operation discards in-flight writes/reserves of that cycle.
- Read latency: 1 cycle (sample at edge N, rdata/rvalid visible after edge N).
- Write-to-read: 0 extra cycles via bypass; write at edge N readable by read sampled at same edge N.
- Reserve-to-busy: busy output and read-side effects visible after edge N (busy output is register, not bypassed).
- All ports independent; any combination of read_en/write_en/reserve_en legal every cycle.
- No combinational path from inputs to outputs.

## Test plan
- Reset: assert reset mid-run after writing 0xDEAD_BEEF to entry 3 -> busy=0, rdata=0, rvalid=0 immediately; read entry 3 after release -> 0.
- Walk all entries: write $random to each of 16 entries via port 0, read back on every read port individually and together -> rdata matches, 1-cycle latency, rvalid=1; read_en low holds previous rdata.
- Bypass: write 0x1234 to entry 5 and read entry 5 on both ports same edge -> rdata=0x1234 next cycle on both.
- Write conflict: write_en=2'b11, both waddr=7, wdata0=0xAAAA, wdata1=0x5555 -> entry 7 reads 0x5555.
- Scoreboard: reserve 9 -> busy[9]=1, read 9 gives rvalid=0; write 9 with 0x77 same cycle as read -> rdata=0x77, rvalid=1, busy[9]=0; reserve+write 9 same edge -> busy[9]=1, data 0x77.
- ZERO_REG=1 build: write 0xFFFF to entry 0 and reserve 0 -> reads 0, rvalid=1, busy[0]=0.
